jk_counter_ctrl: RTL and testbench
==================================

// Module: jk_counter_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH JK flip-flops forming a modulo-(MAX+1) up/down counter.
//  Derives a slow tick from the system clock (OLD_HZ -> NEW_HZ). On each tick it issues
//  J/K commands from the JK excitation table to step the bank.
//  Sits between the board clock/buttons and the JK bank; also drives display/status outputs.
// PARAMETERS
//  OLD_HZ  100_000_000  input clock rate (Hz)
//  NEW_HZ  1            tick rate (Hz); DIV = OLD_HZ/NEW_HZ, DIV>=1 required
//  WIDTH   4            number of JK flip-flops / count width (bits)
//  MAX     9            terminal count; counter range 0..MAX, MAX < 2**WIDTH
// PORTS
//  iClk      in   1      system clock; all state updates on rising edge
//  iReset    in   1      synchronous, active-high reset
//  iStart    in   1      level; IDLE -> RUN
//  iStop     in   1      level; RUN -> IDLE
//  iDir      in   1      1 = count up, 0 = count down; sampled on tick cycles
//  iLoad     in   1      level; load iLoadVal on the next edge
//  iLoadVal  in   WIDTH  value to load; clamped to MAX
//  oJ        out  WIDTH  J command to JK bank (combinational, this cycle)
//  oK        out  WIDTH  K command to JK bank (combinational, this cycle)
//  oCount    out  WIDTH  Q vector of the JK bank (registered)
//  oTick     out  1      one-cycle pulse every DIV cycles while in RUN
//  oBusy     out  1      1 while in RUN
//  oWrap     out  1      one-cycle pulse, registered, on the cycle after a MAX->0 or 0->MAX step
// BEHAVIOUR
//  Reset
//   - State = IDLE; oCount = 0; prescaler = 0.
//   - oTick, oBusy, oWrap = 0; oJ = oK = 0. All inputs ignored while iReset = 1.
//  States
//   - IDLE: oJ = oK = 0 (hold). iStart=1 -> RUN next edge; prescaler cleared on entry.
//   - RUN: prescaler counts 0..DIV-1. oTick = 1 when prescaler == DIV-1, then prescaler wraps to 0.
//     First tick occurs DIV cycles after entering RUN. iStop=1 -> IDLE next edge.
//  Step (RUN and oTick=1)
//   - next = iDir ? (Q==MAX ? 0 : Q+1) : (Q==0 ? MAX : Q-1).
//   - Per bit: J = ~Q & next; K = Q & ~next. Bank takes next on the same edge.
//   - oWrap = 1 for one cycle after a wrap.
//  Load
//   - Allowed in any state: J = L & ~Q, K = ~L & Q, where L = min(iLoadVal, MAX).
//   - oCount = L on the next edge; state unchanged; prescaler cleared.
//  Priority (same cycle)
//   - iReset > iStop > iLoad > tick step > iStart.
//   - iStop on a tick cycle: no step, count held.
//   - iLoad on a tick cycle: load wins; no step, no oWrap.
//  Other rules
//   - Width: next-value arithmetic is WIDTH bits; MAX compares are unsigned.
//   - DIV=1: oTick is high every RUN cycle.
//   - Reset mid-RUN: IDLE and oCount=0 on that edge; no oWrap.
// STRUCTURE
//  - Shared defs header jk_ctrl_defs.vh:
//    - state encodings (ST_IDLE=1'b0, ST_RUN=1'b1)
//    - JK command constants (JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11)
//  - One sub-module jk_cell: one JK flip-flop, sync active-high reset, Q/Qbar.
//    Instantiated WIDTH times via generate; it is clocked every cycle, and J=K=0 holds.
//  - Prescaler, FSM and excitation logic live in jk_counter_ctrl.
// TESTING  (bench params OLD_HZ=10, NEW_HZ=1 -> DIV=10, WIDTH=4, MAX=9)
//  1. iReset=1 for 17 cycles with iStart=1
//     -> oCount=0, oBusy=0, oTick=0, oJ=oK=0 throughout.
//     After release, RUN next edge; oCount 0->1 exactly 10 cycles later.
//  2. Count up from 8, iDir=1
//     -> 8->9 (J=0001, K=0000), then 9->0 (J=0000, K=1001).
//     oWrap=1 one cycle after the 9->0 edge only; ticks spaced 10 cycles.
//  3. iDir=0 from 0 -> tick gives J=1001, K=0000, oCount=9, oWrap pulse.
//     Next tick gives oCount=8 and no oWrap.
//  4. Loads
//     - iLoad with iLoadVal=12 in IDLE -> oCount=9 next edge, oBusy stays 0.
//     - iLoad with iLoadVal=5 in RUN mid-period -> oCount=5 next edge; next tick 10 cycles later.
//  5. iStop, iLoad, iStart all high on a tick cycle
//     -> IDLE, oCount unchanged, oJ=oK=0.
//  6. iReset pulsed while RUN at oCount=7
//     -> oCount=0, oBusy=0, oWrap=0 after that edge; prescaler restarts from 0.

Source files
------------

// File: rtl/jk_counter_ctrl_pkg.sv
// Shared definitions for the JK counter sequencer: controller states and
// the J/K command encodings understood by each flip-flop cell.
package jk_counter_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // {J, K} pair as seen by a single JK flip-flop
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

endpackage

// File: rtl/jk_counter_ctrl_cell.sv
// One JK flip-flop of the counter bank; clocked every cycle, J=K=0 holds,
// synchronous active-high reset clears Q.
module jk_cell
  import jk_counter_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case (jk_cmd_t'({j, k}))
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Sequencer for a bank of JK flip-flops forming a modulo-(MAX+1) up/down
// counter, stepped on a slow tick derived from the system clock.
module jk_counter_ctrl
  import jk_counter_ctrl_pkg::*;
#(
  parameter int OLD_HZ = 100_000_000,
  parameter int NEW_HZ = 1,
  parameter int WIDTH  = 4,
  parameter int MAX    = 9
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iStop,
  input  logic             iDir,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  output logic [WIDTH-1:0] oJ,
  output logic [WIDTH-1:0] oK,
  output logic [WIDTH-1:0] oCount,
  output logic             oTick,
  output logic             oBusy,
  output logic             oWrap
);

  localparam int DIV = OLD_HZ / NEW_HZ;
  // DIV=1 still needs a one-bit prescaler that simply stays at zero
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  state_t           state, state_next;
  logic [PW-1:0]    presc, presc_next;
  logic             wrap_q, wrap_next;
  logic [WIDTH-1:0] q, qbar;
  logic [WIDTH-1:0] target, load_val, step_val;
  logic             tick, step, wrap_cond;

  assign tick      = (state == ST_RUN) && (presc == LAST);
  assign load_val  = (iLoadVal > MAX_V) ? MAX_V : iLoadVal;
  assign step_val  = iDir ? ((q == MAX_V) ? '0 : q + WIDTH'(1))
                          : ((q == '0) ? MAX_V : q - WIDTH'(1));
  assign wrap_cond = iDir ? (q == MAX_V) : (q == '0);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state  <= ST_IDLE;
      presc  <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_next;
      presc  <= presc_next;
      wrap_q <= wrap_next;
    end
  end

  // target is the value the bank must hold after this edge; J/K follow from it
  always_comb begin
    state_next = state;
    presc_next = presc;
    target     = q;
    step       = 1'b0;
    if (iReset) begin
      state_next = ST_IDLE;
      presc_next = '0;
    end else if (iStop) begin
      state_next = ST_IDLE;
      presc_next = '0;
    end else if (iLoad) begin
      target     = load_val;
      presc_next = '0;
    end else if (state == ST_RUN) begin
      presc_next = tick ? '0 : presc + PW'(1);
      if (tick) begin
        target = step_val;
        step   = 1'b1;
      end
    end else begin
      presc_next = '0;
      if (iStart) state_next = ST_RUN;
    end
  end

  assign wrap_next = step & wrap_cond;

  assign oJ     = target & qbar;
  assign oK     = ~target & q;
  assign oCount = q;
  assign oTick  = tick & ~iReset;
  assign oBusy  = (state == ST_RUN) & ~iReset;
  assign oWrap  = wrap_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk   (iClk),
      .reset (iReset),
      .j     (oJ[b]),
      .k     (oK[b]),
      .q     (q[b]),
      .qbar  (qbar[b])
    );
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Self-checking bench for jk_counter_ctrl: table vectors, directed tick
// sequences and random traffic against a modular-arithmetic reference model.
module tb_jk_counter_ctrl;

  localparam int OLD_HZ = 10;
  localparam int NEW_HZ = 1;
  localparam int DIV    = OLD_HZ / NEW_HZ;
  localparam int WIDTH  = 4;
  localparam int MAX    = 9;

  typedef struct packed {
    logic rst, start, stop, dir, load;
    logic [3:0] val;
  } stim_t;

  typedef struct packed {
    stim_t s;
    logic [3:0] count, j, k;
    logic busy, tick;
  } row_t;

  logic iClk, iReset, iStart, iStop, iDir, iLoad;
  logic [WIDTH-1:0] iLoadVal, oJ, oK, oCount;
  logic oTick, oBusy, oWrap;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // reference model state
  bit m_run, m_wrap;
  int m_count, m_presc;

  // outputs sampled mid-cycle by apply_cycle
  logic [3:0] s_count, s_j, s_k;
  logic s_tick, s_busy;

  jk_counter_ctrl #(
    .OLD_HZ(OLD_HZ), .NEW_HZ(NEW_HZ), .WIDTH(WIDTH), .MAX(MAX)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iStop(iStop),
    .iDir(iDir), .iLoad(iLoad), .iLoadVal(iLoadVal),
    .oJ(oJ), .oK(oK), .oCount(oCount),
    .oTick(oTick), .oBusy(oBusy), .oWrap(oWrap)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic stim_t st(bit rst, bit start, bit stop, bit dir, bit load, int val);
    stim_t s;
    s.rst = rst; s.start = start; s.stop = stop; s.dir = dir; s.load = load;
    s.val = 4'(val);
    return s;
  endfunction

  function automatic row_t mk_row(stim_t s, int count, int j, int k, bit busy, bit tick);
    row_t r;
    r.s = s; r.count = 4'(count); r.j = 4'(j); r.k = 4'(k);
    r.busy = busy; r.tick = tick;
    return r;
  endfunction

  task automatic check_output(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // one clock cycle: drive, compare against the model mid-cycle, clock, advance model
  task automatic apply_stimulus(stim_t s);
    int target, naive, lim;
    bit tick_e, busy_e, stepped;
    logic [3:0] exp_j, exp_k;
    iReset = s.rst; iStart = s.start; iStop = s.stop;
    iDir = s.dir; iLoad = s.load; iLoadVal = s.val;
    #2;
    tick_e  = !s.rst && m_run && (m_presc == DIV - 1);
    busy_e  = !s.rst && m_run;
    target  = m_count;
    stepped = 1'b0;
    naive   = m_count;
    lim     = (int'(s.val) > MAX) ? MAX : int'(s.val);
    if (!s.rst && !s.stop) begin
      if (s.load) begin
        target = lim;
      end else if (tick_e) begin
        naive   = s.dir ? m_count + 1 : m_count - 1;
        target  = s.dir ? (m_count + 1) % (MAX + 1) : (m_count + MAX) % (MAX + 1);
        stepped = 1'b1;
      end
    end
    exp_j = 4'(target) & ~4'(m_count);
    exp_k = ~4'(target) & 4'(m_count);
    s_count = oCount; s_j = oJ; s_k = oK; s_tick = oTick; s_busy = oBusy;
    check_output($sformatf("model{count,J,K,tick,busy,wrap}"),
                 int'({oCount, oJ, oK, oTick, oBusy, oWrap}),
                 int'({4'(m_count), exp_j, exp_k, tick_e, busy_e, m_wrap}));
    @(posedge iClk);
    #1;
    cyc++;
    if (s.rst) begin
      m_run = 0; m_count = 0; m_presc = 0; m_wrap = 0;
    end else begin
      m_wrap  = stepped && (target != naive);
      m_count = target;
      if (s.stop) begin
        m_run = 0; m_presc = 0;
      end else if (s.load) begin
        m_presc = 0;
      end else if (m_run) begin
        m_presc = (m_presc + 1) % DIV;
      end else begin
        m_presc = 0;
        if (s.start) m_run = 1;
      end
    end
  endtask

  task automatic plain(int n, bit dir);
    for (int i = 0; i < n; i++) apply_stimulus(st(0, 0, 0, dir, 0, 0));
  endtask

  initial begin
    row_t tbl[11];
    iReset = 1'b1; iStart = 1'b0; iStop = 1'b0; iDir = 1'b0;
    iLoad = 1'b0; iLoadVal = '0;
    m_run = 0; m_count = 0; m_presc = 0; m_wrap = 0;
    @(posedge iClk);
    #1;

    // loads, clamping and start priority from IDLE
    tbl[0]  = mk_row(st(0, 0, 0, 1, 1, 12), 0, 9, 0, 0, 0);
    tbl[1]  = mk_row(st(0, 0, 0, 1, 1, 3),  9, 2, 8, 0, 0);
    tbl[2]  = mk_row(st(0, 0, 0, 1, 1, 15), 3, 8, 2, 0, 0);
    tbl[3]  = mk_row(st(0, 0, 0, 1, 0, 0),  9, 0, 0, 0, 0);
    tbl[4]  = mk_row(st(0, 0, 0, 1, 1, 0),  9, 0, 9, 0, 0);
    tbl[5]  = mk_row(st(0, 1, 0, 1, 1, 9),  0, 9, 0, 0, 0);
    tbl[6]  = mk_row(st(0, 0, 0, 1, 0, 0),  9, 0, 0, 0, 0);
    tbl[7]  = mk_row(st(0, 1, 0, 1, 0, 0),  9, 0, 0, 0, 0);
    tbl[8]  = mk_row(st(0, 0, 0, 1, 0, 0),  9, 0, 0, 1, 0);
    tbl[9]  = mk_row(st(1, 0, 0, 1, 0, 0),  9, 0, 0, 0, 0);
    tbl[10] = mk_row(st(0, 0, 0, 1, 0, 0),  0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(tbl[i].s);
      check_output($sformatf("tbl%0d_count", i), s_count, tbl[i].count);
      check_output($sformatf("tbl%0d_J", i), s_j, tbl[i].j);
      check_output($sformatf("tbl%0d_K", i), s_k, tbl[i].k);
      check_output($sformatf("tbl%0d_busy", i), s_busy, tbl[i].busy);
      check_output($sformatf("tbl%0d_tick", i), s_tick, tbl[i].tick);
    end

    // long reset with start held, then first tick after DIV cycles
    for (int c = 0; c < 17; c++) begin
      apply_stimulus(st(1, 1, 0, 1, 0, 0));
      check_output("rst_count", s_count, 0);
      check_output("rst_busy", s_busy, 0);
      check_output("rst_tick", s_tick, 0);
      check_output("rst_jk", int'({s_j, s_k}), 0);
    end
    apply_stimulus(st(0, 1, 0, 1, 0, 0));
    check_output("start_busy", oBusy, 1);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(st(0, 0, 0, 1, 0, 0));
      check_output("first_tick_pulse", s_tick, (k == 10) ? 1 : 0);
      check_output("first_tick_count", oCount, (k == 10) ? 1 : 0);
    end

    // count up 8 -> 9 -> 0 with wrap pulse
    apply_stimulus(st(0, 0, 0, 1, 1, 8));
    check_output("load8_count", oCount, 8);
    plain(9, 1);
    apply_stimulus(st(0, 0, 0, 1, 0, 0));
    check_output("up89_tick", s_tick, 1);
    check_output("up89_J", s_j, 1);
    check_output("up89_K", s_k, 0);
    check_output("up89_count", oCount, 9);
    check_output("up89_wrap", oWrap, 0);
    plain(9, 1);
    apply_stimulus(st(0, 0, 0, 1, 0, 0));
    check_output("up90_J", s_j, 0);
    check_output("up90_K", s_k, 9);
    check_output("up90_count", oCount, 0);
    check_output("up90_wrap", oWrap, 1);
    plain(1, 1);
    check_output("up90_wrap_end", oWrap, 0);

    // count down 0 -> 9 -> 8
    plain(8, 0);
    apply_stimulus(st(0, 0, 0, 0, 0, 0));
    check_output("dn09_tick", s_tick, 1);
    check_output("dn09_J", s_j, 9);
    check_output("dn09_K", s_k, 0);
    check_output("dn09_count", oCount, 9);
    check_output("dn09_wrap", oWrap, 1);
    plain(9, 0);
    apply_stimulus(st(0, 0, 0, 0, 0, 0));
    check_output("dn98_count", oCount, 8);
    check_output("dn98_wrap", oWrap, 0);

    // clamped load in IDLE, mid-period load in RUN
    apply_stimulus(st(0, 0, 1, 1, 0, 0));
    check_output("stop_busy", oBusy, 0);
    apply_stimulus(st(0, 0, 0, 1, 1, 12));
    check_output("ld12_J", s_j, 1);
    check_output("ld12_K", s_k, 0);
    check_output("ld12_count", oCount, 9);
    check_output("ld12_busy", oBusy, 0);
    apply_stimulus(st(0, 1, 0, 1, 0, 0));
    plain(4, 1);
    apply_stimulus(st(0, 0, 0, 1, 1, 5));
    check_output("ld5_J", s_j, 4);
    check_output("ld5_K", s_k, 8);
    check_output("ld5_count", oCount, 5);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(st(0, 0, 0, 1, 0, 0));
      check_output("ld5_tick_spacing", s_tick, (k == 10) ? 1 : 0);
    end
    check_output("ld5_next_count", oCount, 6);

    // stop, load and start together on a tick cycle
    plain(9, 1);
    apply_stimulus(st(0, 1, 1, 1, 1, 3));
    check_output("sls_J", s_j, 0);
    check_output("sls_K", s_k, 0);
    check_output("sls_busy", oBusy, 0);
    check_output("sls_count", oCount, 6);

    // reset mid-RUN at count 7
    apply_stimulus(st(0, 1, 0, 1, 0, 0));
    apply_stimulus(st(0, 0, 0, 1, 1, 7));
    plain(3, 1);
    apply_stimulus(st(1, 0, 0, 1, 0, 0));
    check_output("midrst_count", oCount, 0);
    check_output("midrst_busy", oBusy, 0);
    check_output("midrst_wrap", oWrap, 0);
    apply_stimulus(st(0, 1, 0, 1, 0, 0));
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(st(0, 0, 0, 1, 0, 0));
      check_output("midrst_restart", oCount, (k == 10) ? 1 : 0);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.rst   = ($urandom_range(0, 99) < 2);
      s.start = ($urandom_range(0, 3) == 0);
      s.stop  = ($urandom_range(0, 39) == 0);
      s.load  = ($urandom_range(0, 24) == 0);
      s.dir   = $urandom_range(0, 1) != 0;
      s.val   = 4'($urandom_range(0, 15));
      apply_stimulus(s);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
